spatz_vfu_issue_ctrl: RTL and testbench
=======================================

// Module: spatz_vfu_issue_ctrl
// PURPOSE
//  Issue controller between the Spatz decoder/controller and spatz_vfu. Buffers VFU-bound
//  spatz_req_t requests in an in-order queue and tracks issued-but-unretired instructions
//  in a per-ID scoreboard. Blocks dispatch on vreg RAW/WAR/WAW hazards and on ID reuse.
//  Converts VFU responses into registered retire pulses for the controller.
// PARAMETERS
//  Depth    4      issue queue entries (power of 2, >=2)
//  NrIds    4      scoreboard entries; request id is [$clog2(NrIds)-1:0]
// PORTS
//  clk_i            in   1            clock
//  rst_ni           in   1            asynchronous active-low reset
//  spatz_req_i      in   spatz_req_t  request from controller (ex_unit==VFU only)
//  spatz_req_valid_i in  1            request valid
//  spatz_req_ready_o out 1            request accepted when valid&&ready
//  vfu_req_o        out  spatz_req_t  request to spatz_vfu
//  vfu_req_valid_o  out  1            dispatch valid
//  vfu_req_ready_i  in   1            spatz_vfu ready
//  vfu_rsp_valid_i  in   1            spatz_vfu completion
//  vfu_rsp_i        in   vfu_rsp_t    completion id
//  retire_valid_o   out  1            retire pulse to controller
//  retire_id_o      out  $clog2(NrIds) retired id
//  busy_o           out  1            queue non-empty or any scoreboard entry pending
// BEHAVIOUR
//  Reset: queue empty, scoreboard cleared; all outputs 0 except spatz_req_ready_o=1.
//  Reset asserted mid-operation drops queued and in-flight state; no retire is emitted.
//  Queue: spatz_req_ready_o = !full. Push on valid&&ready&&ex_unit==VFU. Requests with
//   ex_unit!=VFU are ignored (never accepted). Read and write pointers wrap modulo Depth.
//   When full, a same-cycle pop does not enable a push (ready is !full only).
//  Dispatch: vfu_req_o = queue head; vfu_req_valid_o = !empty && !hazard && !zero_vl.
//   Minimum latency accept->vfu_req_valid_o is 1 cycle (queue is registered).
//   Once asserted, valid stays high and vfu_req_o stays stable until vfu_req_ready_i.
//  hazard = pending[head.id], or for any pending entry p:
//   (head.use_vs1 && head.vs1==vd[p]), or (head.use_vs2 && head.vs2==vd[p]),
//   or ((head.use_vd || head.vd_is_src) && head.vd==vd[p]) where use_vd[p]=1.
//   The check uses registered scoreboard state. A retire clearing p in cycle t unblocks
//   dispatch at t+1 (no same-cycle bypass).
//  Scoreboard: on dispatch handshake set pending[id], vd[id], use_vd[id] and pop head.
//   On vfu_rsp_valid_i clear pending[vfu_rsp_i.id]. Set and clear on different ids in
//   the same cycle both take effect. Same-id set+clear cannot occur (blocked by hazard).
//   vfu_rsp_valid_i for a non-pending id is ignored for the scoreboard but still retired.
//  zero_vl: a head with vl==0 is never sent to the VFU. It pops in one cycle and produces
//   a retire with its id, even if hazard is high.
//  Retire: retire_valid_o/retire_id_o registered, 1 cycle after vfu_rsp_valid_i or after a
//   zero_vl pop. If both occur in one cycle, the VFU response retires first and the zero_vl
//   pop is held until the next cycle.
//  busy_o is combinational from registered state.
// CONFIGURATION
//  SPATZ_VFU_ISSUE_BYPASS_EN defined: when the queue is empty, an incoming request is
//   forwarded to vfu_req_o in the same cycle, provided it has no hazard, vl!=0 and
//   vfu_req_ready_i=1. On that handshake it is not written to the queue.
//   Request accept->dispatch latency is 0.
//  Undefined: every request passes through the queue; latency >= 1 cycle.
// TESTING
//  Single op id0 vd=3 vl=8, VFU ready: dispatch at cycle 1, rsp at 5 -> retire id0 at 6.
//  id0 vd=3 in flight; id1 vs2=3 -> held until cycle after rsp id0, then dispatches.
//  Fill 4 independent ops with vfu_req_ready_i=0 -> spatz_req_ready_o=0; pop one -> ready=1 next cycle.
//  vl=0 request id2 -> no vfu_req_valid_o; retire id2 one cycle after pop.
//  rsp id0 and dispatch id1 in the same cycle -> pending={id1}, busy_o stays 1.
//  Reset mid-flight with 2 queued and 1 pending -> all outputs 0, ready=1, no retire after.

Source files
------------

// File: rtl/spatz_vfu_issue_ctrl.sv
// Issue controller for spatz_vfu: in-order request queue, per-id vreg scoreboard and retire pulses.
// Optional macro SPATZ_VFU_ISSUE_BYPASS_EN forwards a request straight to the VFU when the queue is empty.
package spatz_vfu_issue_pkg;
  localparam int unsigned NrIds   = 4;
  localparam int unsigned IdWidth = $clog2(NrIds);

  typedef enum logic [1:0] {EX_LSU = 2'd0, EX_VFU = 2'd1, EX_SLD = 2'd2, EX_CON = 2'd3} ex_unit_e;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    ex_unit_e           ex_unit;
    logic [4:0]         vd;
    logic [4:0]         vs1;
    logic [4:0]         vs2;
    logic               use_vd;
    logic               vd_is_src;
    logic               use_vs1;
    logic               use_vs2;
    logic [7:0]         vl;
  } spatz_req_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
  } vfu_rsp_t;
endpackage

module spatz_vfu_issue_ctrl
  import spatz_vfu_issue_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned NrIds = spatz_vfu_issue_pkg::NrIds
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  spatz_req_t               spatz_req_i,
  input  logic                     spatz_req_valid_i,
  output logic                     spatz_req_ready_o,
  output spatz_req_t               vfu_req_o,
  output logic                     vfu_req_valid_o,
  input  logic                     vfu_req_ready_i,
  input  logic                     vfu_rsp_valid_i,
  input  vfu_rsp_t                 vfu_rsp_i,
  output logic                     retire_valid_o,
  output logic [$clog2(NrIds)-1:0] retire_id_o,
  output logic                     busy_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdW  = $clog2(NrIds);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  spatz_req_t mem_reg [Depth];
  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] count_reg, count_next;

  logic [NrIds-1:0]      pending_reg;
  logic [NrIds-1:0][4:0] vd_reg;
  logic [NrIds-1:0]      use_vd_reg;
  logic [NrIds-1:0]      set_id, clr_id;

  logic           retire_valid_reg, retire_valid_next;
  logic [IdW-1:0] retire_id_reg, retire_id_next;

  spatz_req_t head;
  logic empty, full, req_is_vfu, head_hazard, head_zero;
  logic zero_pop, dispatch, bypass, push, pop;

  // Source operands are checked against every in-flight vd; the destination only against writers.
  function automatic logic hazard_f(input spatz_req_t r, input logic [NrIds-1:0] pend,
                                    input logic [NrIds-1:0][4:0] vdv, input logic [NrIds-1:0] usev);
    logic h;
    h = pend[r.id];
    for (int p = 0; p < NrIds; p++) begin
      if (pend[p]) begin
        if (r.use_vs1 && r.vs1 == vdv[p]) h = 1'b1;
        if (r.use_vs2 && r.vs2 == vdv[p]) h = 1'b1;
        if ((r.use_vd || r.vd_is_src) && usev[p] && r.vd == vdv[p]) h = 1'b1;
      end
    end
    return h;
  endfunction

  always_comb begin
    head        = mem_reg[rd_ptr_reg];
    empty       = (count_reg == '0);
    full        = (count_reg == DepthCnt);
    req_is_vfu  = (spatz_req_i.ex_unit == EX_VFU);
    head_hazard = hazard_f(head, pending_reg, vd_reg, use_vd_reg);
    head_zero   = (head.vl == '0);
    // A VFU response owns the retire port this cycle, so a zero-vl head waits one cycle.
    zero_pop    = !empty && head_zero && !vfu_rsp_valid_i;
`ifdef SPATZ_VFU_ISSUE_BYPASS_EN
    bypass = empty && spatz_req_valid_i && req_is_vfu && (spatz_req_i.vl != '0) && vfu_req_ready_i &&
             !hazard_f(spatz_req_i, pending_reg, vd_reg, use_vd_reg);
    vfu_req_o       = empty ? spatz_req_i : head;
    vfu_req_valid_o = empty ? bypass : (!head_hazard && !head_zero);
`else
    bypass          = 1'b0;
    vfu_req_o       = head;
    vfu_req_valid_o = !empty && !head_hazard && !head_zero;
`endif
    dispatch    = vfu_req_valid_o && vfu_req_ready_i;
    pop         = (dispatch && !bypass) || zero_pop;
    push        = spatz_req_valid_i && !full && req_is_vfu && !bypass;
    wr_ptr_next = push ? wr_ptr_reg + PtrW'(1) : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + PtrW'(1) : rd_ptr_reg;
    count_next  = count_reg + CntW'(push) - CntW'(pop);

    retire_valid_next = vfu_rsp_valid_i || zero_pop;
    retire_id_next    = retire_id_reg;
    if (vfu_rsp_valid_i) retire_id_next = IdW'(vfu_rsp_i.id);
    else if (zero_pop)   retire_id_next = IdW'(head.id);
  end

  for (genvar gi = 0; gi < NrIds; gi++) begin : gen_sb_ctrl
    assign set_id[gi] = dispatch && (vfu_req_o.id == IdWidth'(gi));
    assign clr_id[gi] = vfu_rsp_valid_i && (vfu_rsp_i.id == IdWidth'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_reg[i] <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      pending_reg      <= '0;
      vd_reg           <= '0;
      use_vd_reg       <= '0;
      retire_valid_reg <= 1'b0;
      retire_id_reg    <= '0;
    end else begin
      if (push) mem_reg[wr_ptr_reg] <= spatz_req_i;
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      retire_valid_reg <= retire_valid_next;
      retire_id_reg    <= retire_id_next;
      for (int i = 0; i < NrIds; i++) begin
        if (set_id[i]) begin
          pending_reg[i] <= 1'b1;
          vd_reg[i]      <= vfu_req_o.vd;
          use_vd_reg[i]  <= vfu_req_o.use_vd;
        end else if (clr_id[i]) begin
          pending_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign spatz_req_ready_o = !full;
  assign retire_valid_o    = retire_valid_reg;
  assign retire_id_o       = retire_id_reg;
  assign busy_o            = !empty || (|pending_reg);

endmodule

// File: tb/tb_spatz_vfu_issue_ctrl.sv
// Randomized bench for spatz_vfu_issue_ctrl: a transaction-level reference model feeds
// expected dispatches/retires into queues that a negedge monitor checks.
module tb_spatz_vfu_issue_ctrl;
  import spatz_vfu_issue_pkg::*;

  localparam int Depth = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  spatz_req_t spatz_req_i;
  logic       spatz_req_valid_i;
  logic       spatz_req_ready_o;
  spatz_req_t vfu_req_o;
  logic       vfu_req_valid_o;
  logic       vfu_req_ready_i;
  logic       vfu_rsp_valid_i;
  vfu_rsp_t   vfu_rsp_i;
  logic       retire_valid_o;
  logic [1:0] retire_id_o;
  logic       busy_o;

  always #5 clk_i = ~clk_i;

  spatz_vfu_issue_ctrl #(.Depth(Depth), .NrIds(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .spatz_req_i(spatz_req_i), .spatz_req_valid_i(spatz_req_valid_i), .spatz_req_ready_o(spatz_req_ready_o),
    .vfu_req_o(vfu_req_o), .vfu_req_valid_o(vfu_req_valid_o), .vfu_req_ready_i(vfu_req_ready_i),
    .vfu_rsp_valid_i(vfu_rsp_valid_i), .vfu_rsp_i(vfu_rsp_i),
    .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o), .busy_o(busy_o)
  );

  typedef struct {int id; int due;} stamp_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit rsp_en = 1'b1;

  spatz_req_t model_q[$];     // accepted, not yet dispatched or dropped
  spatz_req_t inflight[int];  // dispatched, awaiting VFU response
  stamp_t     exp_ret_q[$];   // expected retire id and cycle
  stamp_t     vfu_jobs[$];    // VFU model: id and earliest response cycle

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit model_hazard(input spatz_req_t r);
    spatz_req_t p;
    if (inflight.exists(int'(r.id))) return 1'b1;
    foreach (inflight[k]) begin
      p = inflight[k];
      if (r.use_vs1 && r.vs1 == p.vd) return 1'b1;
      if (r.use_vs2 && r.vs2 == p.vd) return 1'b1;
      if ((r.use_vd || r.vd_is_src) && p.use_vd && r.vd == p.vd) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Monitor: inputs and outputs are stable at negedge; compare, then advance the model.
  always @(negedge clk_i) begin
    bit exp_valid;
    int size_before;
    spatz_req_t hd;
    if (!rst_ni) begin
      model_q.delete();
      inflight.delete();
      exp_ret_q.delete();
      chk("rst_vfu_valid", 64'(vfu_req_valid_o), 64'(0));
      chk("rst_retire", 64'(retire_valid_o), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_ready", 64'(spatz_req_ready_o), 64'(1));
    end else begin
      size_before = model_q.size();
      if (retire_valid_o) begin
        if (exp_ret_q.size() == 0) chk("retire_unexpected", 64'(1), 64'(0));
        else begin
          chk("retire_cycle", 64'(cyc), 64'(exp_ret_q[0].due));
          chk("retire_id", 64'(retire_id_o), 64'(exp_ret_q[0].id));
          void'(exp_ret_q.pop_front());
        end
      end else if (exp_ret_q.size() > 0 && exp_ret_q[0].due <= cyc) begin
        chk("retire_missing", 64'(0), 64'(1));
        void'(exp_ret_q.pop_front());
      end
      chk("busy", 64'(busy_o), 64'(size_before != 0 || inflight.num() != 0));
      chk("req_ready", 64'(spatz_req_ready_o), 64'(size_before < Depth));
      exp_valid = size_before > 0 && model_q[0].vl != 0 && !model_hazard(model_q[0]);
      chk("vfu_valid", 64'(vfu_req_valid_o), 64'(exp_valid));
      if (exp_valid && vfu_req_valid_o) chk("vfu_req", 64'(vfu_req_o), 64'(model_q[0]));

      if (vfu_rsp_valid_i) begin
        if (inflight.exists(int'(vfu_rsp_i.id))) inflight.delete(int'(vfu_rsp_i.id));
        exp_ret_q.push_back('{int'(vfu_rsp_i.id), cyc + 1});
      end
      if (size_before > 0) begin
        hd = model_q[0];
        if (hd.vl == 0) begin
          if (!vfu_rsp_valid_i) begin
            void'(model_q.pop_front());
            exp_ret_q.push_back('{int'(hd.id), cyc + 1});
          end
        end else if (exp_valid && vfu_req_ready_i) begin
          inflight[int'(hd.id)] = hd;
          void'(model_q.pop_front());
          vfu_jobs.push_back('{int'(hd.id), cyc + 1 + int'($urandom_range(0, 6))});
        end
      end
      if (spatz_req_valid_i && size_before < Depth && spatz_req_i.ex_unit == EX_VFU)
        model_q.push_back(spatz_req_i);
    end
  end

  // VFU model: responds to dispatched ids out of order, occasionally with a spurious id.
  initial begin
    int idx;
    int cand;
    bit used;
    vfu_rsp_valid_i = 1'b0;
    vfu_rsp_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      vfu_rsp_valid_i = 1'b0;
      if (!rst_ni) begin
        vfu_jobs.delete();
        continue;
      end
      if (!rsp_en) continue;
      idx = -1;
      foreach (vfu_jobs[k]) if (idx < 0 && vfu_jobs[k].due <= cyc) idx = k;
      if (idx >= 0 && $urandom_range(0, 9) < 8) begin
        vfu_rsp_valid_i = 1'b1;
        vfu_rsp_i.id = IdWidth'(vfu_jobs[idx].id);
        vfu_jobs.delete(idx);
      end else if ($urandom_range(0, 49) == 0) begin
        cand = int'($urandom_range(0, 3));
        used = 1'b0;
        foreach (vfu_jobs[k]) if (vfu_jobs[k].id == cand) used = 1'b1;
        if (!used) begin
          vfu_rsp_valid_i = 1'b1;
          vfu_rsp_i.id = IdWidth'(cand);
        end
      end
    end
  end

  function automatic spatz_req_t mk(input int id, input int vd, input int vs2, input bit use_vs2, input int vl);
    spatz_req_t r;
    r = '0;
    r.id = IdWidth'(id);
    r.ex_unit = EX_VFU;
    r.vd = 5'(vd);
    r.use_vd = 1'b1;
    r.vs2 = 5'(vs2);
    r.use_vs2 = use_vs2;
    r.vl = 8'(vl);
    return r;
  endfunction

  function automatic spatz_req_t rand_req();
    spatz_req_t r;
    r.id = IdWidth'($urandom_range(0, 3));
    r.ex_unit = ($urandom_range(0, 7) == 0) ? ex_unit_e'(2'($urandom_range(0, 3))) : EX_VFU;
    r.vd = 5'($urandom_range(0, 7));
    r.vs1 = 5'($urandom_range(0, 7));
    r.vs2 = 5'($urandom_range(0, 7));
    r.use_vd = 1'($urandom_range(0, 1));
    r.vd_is_src = 1'($urandom_range(0, 1));
    r.use_vs1 = 1'($urandom_range(0, 1));
    r.use_vs2 = 1'($urandom_range(0, 1));
    r.vl = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input spatz_req_t r);
    bit acc;
    acc = 1'b0;
    spatz_req_valid_i = 1'b1;
    spatz_req_i = r;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk_i);
      acc = spatz_req_ready_o;
      @(posedge clk_i);
      #1;
    end
    spatz_req_valid_i = 1'b0;
    if (!acc) chk("send_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    spatz_req_i = '0;
    spatz_req_valid_i = 1'b0;
    vfu_req_ready_i = 1'b1;
    idle(3);
    rst_ni = 1'b1;

    // Single op, then a RAW-dependent op held until the producer retires.
    send(mk(0, 3, 0, 1'b0, 8));
    idle(10);
    rsp_en = 1'b0;
    send(mk(0, 3, 0, 1'b0, 8));
    send(mk(1, 5, 3, 1'b1, 4));
    idle(5);
    rsp_en = 1'b1;
    idle(15);

    // Fill the queue with the VFU stalled, then release one slot.
    vfu_req_ready_i = 1'b0;
    for (int i = 0; i < Depth; i++) send(mk(i, 8 + i, 20, 1'b0, 2));
    @(negedge clk_i);
    chk("full_ready", 64'(spatz_req_ready_o), 64'(0));
    @(posedge clk_i);
    #1;
    vfu_req_ready_i = 1'b1;
    idle(25);

    // Zero-length op retires without reaching the VFU.
    send(mk(2, 6, 0, 1'b0, 0));
    idle(5);

    // Reset with two queued and one in flight: nothing may retire afterwards.
    rsp_en = 1'b0;
    send(mk(0, 1, 0, 1'b0, 5));
    idle(2);
    vfu_req_ready_i = 1'b0;
    send(mk(1, 2, 0, 1'b0, 5));
    send(mk(2, 4, 0, 1'b0, 5));
    rst_ni = 1'b0;
    idle(2);
    rst_ni = 1'b1;
    rsp_en = 1'b1;
    vfu_req_ready_i = 1'b1;
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      spatz_req_valid_i = ($urandom_range(0, 9) < 6);
      spatz_req_i = rand_req();
      vfu_req_ready_i = ($urandom_range(0, 9) < 7);
      if (i == 1500) rst_ni = 1'b0;
      if (i == 1502) rst_ni = 1'b1;
      idle(1);
    end

    spatz_req_valid_i = 1'b0;
    vfu_req_ready_i = 1'b1;
    idle(200);
    @(negedge clk_i);
    chk("drain_busy", 64'(busy_o), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
